ztex_host_link: RTL and testbench

Host-side initiator for the ZTEX byte-strobe link used by the single-core Litecoin hashcore wrapper. It serialises one 672-bit work unit (target, data3, data2, data1) onto `read`/`rd_clk` as 84 toggle-strobed bytes. It polls the 96-bit result word (hash2, nonce, golden_nonce) via `wr_start`/`wr_clk`/`write`. It sits in a controller FPGA or a system testbench as a drop-in model of the EZ-USB side, so the miner can be driven without USB firmware.

---
 rtl/ztex_host_link_if.sv | 32 +++
 rtl/ztex_host_link.sv | 183 ++++++++++++++++++
 tb/tb_ztex_host_link.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ztex_host_link_if.sv
// ztex_host_link_if: bundles the work/poll/result handshake and the ZTEX
// byte-strobe pins. The master modport is the host-side initiator; the slave
// modport is its counterpart (work source, result sink and the miner pins).
interface ztex_host_link_if;
  logic         work_valid;
  logic         work_ready;
  logic [671:0] work_data;
  logic         poll_req;
  logic         busy;
  logic         result_valid;
  logic [31:0]  golden_nonce;
  logic [31:0]  nonce;
  logic [31:0]  hash2;
  logic         golden_new;
  logic [7:0]   read;
  logic         rd_clk;
  logic         wr_start;
  logic         wr_clk;
  logic [7:0]   write;

  modport master (
    input  work_valid, work_data, poll_req, write,
    output work_ready, busy, result_valid, golden_nonce, nonce, hash2,
           golden_new, read, rd_clk, wr_start, wr_clk
  );

  modport slave (
    output work_valid, work_data, poll_req, write,
    input  work_ready, busy, result_valid, golden_nonce, nonce, hash2,
           golden_new, read, rd_clk, wr_start, wr_clk
  );
endinterface

// File: rtl/ztex_host_link.sv
// ztex_host_link: host-side initiator for the ZTEX byte-strobe link.
// Loads a 672-bit work unit as 84 toggle-strobed bytes (LSB byte first) and
// polls the 96-bit result word with 12 toggle-strobed samples.
// Optional feature: define ZTEXHOST_GOLDEN_DEDUP_EN to qualify golden_new
// so it only rises when the golden nonce differs from the last one reported.
module ztex_host_link #(
  parameter int STROBE_CYC = 8,
  parameter int SETTLE_CYC = 16
) (
  input  logic             clk,
  input  logic             reset,
  ztex_host_link_if.master bus
);

  // The cycle counter is 8 bits; it only grows if the settle time needs more.
  localparam int CNT_W = (SETTLE_CYC > 256) ? $clog2(SETTLE_CYC) : 8;
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [6:0]       LOAD_LAST   = 7'd83;
  localparam logic [6:0]       SAMPLE_LAST = 7'd11;

  typedef enum logic [2:0] {
    IDLE, LD_DATA, LD_STROBE, PL_START, PL_SETTLE, PL_SAMPLE, PL_STROBE, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [6:0]       idx_q, idx_d;
  logic [671:0]     shift_q, shift_d;
  logic [95:0]      asm_q, asm_d;
  logic             rd_clk_q, rd_clk_d;
  logic             wr_start_q, wr_start_d;
  logic             wr_clk_q, wr_clk_d;
  logic             result_valid_q, result_valid_d;
  logic             golden_new_q, golden_new_d;
  logic [31:0]      golden_q, golden_d;
  logic [31:0]      nonce_q, nonce_d;
  logic [31:0]      hash2_q, hash2_d;
`ifdef ZTEXHOST_GOLDEN_DEDUP_EN
  logic [31:0]      prev_golden_q, prev_golden_d;
`endif

  // Sequencer: walks the load and poll sequences and computes every next value.
  always_comb begin
    state_d        = state_q;
    cyc_d          = (state_q == IDLE) ? '0 : cyc_q + CNT_W'(1);
    idx_d          = idx_q;
    shift_d        = shift_q;
    asm_d          = asm_q;
    rd_clk_d       = rd_clk_q;
    wr_start_d     = wr_start_q;
    wr_clk_d       = wr_clk_q;
    result_valid_d = 1'b0;
    golden_new_d   = 1'b0;
    golden_d       = golden_q;
    nonce_d        = nonce_q;
    hash2_d        = hash2_q;
`ifdef ZTEXHOST_GOLDEN_DEDUP_EN
    prev_golden_d  = prev_golden_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.work_valid) begin
          shift_d = bus.work_data;
          idx_d   = '0;
          state_d = LD_DATA;
        end else if (bus.poll_req) begin
          idx_d      = '0;
          wr_start_d = 1'b1;
          state_d    = PL_START;
        end
      end
      LD_DATA: begin
        if (cyc_q == STROBE_LAST) begin
          rd_clk_d = ~rd_clk_q;
          state_d  = LD_STROBE;
        end
      end
      LD_STROBE: begin
        if (cyc_q == STROBE_LAST) begin
          if (idx_q == LOAD_LAST) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 7'd1;
            shift_d = {8'h00, shift_q[671:8]};
            state_d = LD_DATA;
          end
        end
      end
      PL_START: begin
        if (cyc_q == STROBE_LAST) begin
          wr_start_d = 1'b0;
          state_d    = PL_SETTLE;
        end
      end
      PL_SETTLE: begin
        if (cyc_q == SETTLE_LAST) state_d = PL_SAMPLE;
      end
      PL_SAMPLE: begin
        if (cyc_q == '0) asm_d = {bus.write, asm_q[95:8]};
        if (cyc_q == '0 && idx_q == SAMPLE_LAST) begin
          golden_d       = asm_d[31:0];
          nonce_d        = asm_d[63:32];
          hash2_d        = asm_d[95:64];
          result_valid_d = 1'b1;
`ifdef ZTEXHOST_GOLDEN_DEDUP_EN
          golden_new_d   = (asm_d[31:0] != prev_golden_q);
          prev_golden_d  = asm_d[31:0];
`else
          golden_new_d   = 1'b1;
`endif
          state_d        = DONE;
        end else if (cyc_q == STROBE_LAST) begin
          wr_clk_d = ~wr_clk_q;
          idx_d    = (idx_q == SAMPLE_LAST) ? idx_q : idx_q + 7'd1;
          state_d  = PL_STROBE;
        end
      end
      PL_STROBE: begin
        if (cyc_q == STROBE_LAST) state_d = PL_SAMPLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q) cyc_d = '0;
  end

  // State and output registers; reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cyc_q          <= '0;
      idx_q          <= '0;
      shift_q        <= '0;
      asm_q          <= '0;
      rd_clk_q       <= 1'b0;
      wr_start_q     <= 1'b0;
      wr_clk_q       <= 1'b0;
      result_valid_q <= 1'b0;
      golden_new_q   <= 1'b0;
      golden_q       <= '0;
      nonce_q        <= '0;
      hash2_q        <= '0;
`ifdef ZTEXHOST_GOLDEN_DEDUP_EN
      prev_golden_q  <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cyc_q          <= cyc_d;
      idx_q          <= idx_d;
      shift_q        <= shift_d;
      asm_q          <= asm_d;
      rd_clk_q       <= rd_clk_d;
      wr_start_q     <= wr_start_d;
      wr_clk_q       <= wr_clk_d;
      result_valid_q <= result_valid_d;
      golden_new_q   <= golden_new_d;
      golden_q       <= golden_d;
      nonce_q        <= nonce_d;
      hash2_q        <= hash2_d;
`ifdef ZTEXHOST_GOLDEN_DEDUP_EN
      prev_golden_q  <= prev_golden_d;
`endif
    end
  end

  assign bus.work_ready   = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.read         = shift_q[7:0];
  assign bus.rd_clk       = rd_clk_q;
  assign bus.wr_start     = wr_start_q;
  assign bus.wr_clk       = wr_clk_q;
  assign bus.result_valid = result_valid_q;
  assign bus.golden_new   = golden_new_q;
  assign bus.golden_nonce = golden_q;
  assign bus.nonce        = nonce_q;
  assign bus.hash2        = hash2_q;

endmodule

// File: tb/tb_ztex_host_link.sv
// tb_ztex_host_link: scoreboard bench for ztex_host_link. Instance A (S=4,
// T=8) covers load, poll, arbitration, reset abort and golden_new; instance
// B (S=255, T=510) covers the long-strobe load timing.
module tb_ztex_host_link;

  localparam int S_A = 4;
  localparam int T_A = 8;
  localparam int S_B = 255;
  localparam int T_B = 510;

  typedef logic [671:0] wide_t;
  typedef struct packed {
    logic [31:0] g;
    logic [31:0] n;
    logic [31:0] h;
    logic        gn;
  } res_t;

  logic clk = 1'b0;
  logic reset_a, reset_b;
  int   checks = 0;
  int   errors = 0;

  ztex_host_link_if bus_a ();
  ztex_host_link_if bus_b ();

  ztex_host_link #(.STROBE_CYC(S_A), .SETTLE_CYC(T_A)) dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a.master)
  );
  ztex_host_link #(.STROBE_CYC(S_B), .SETTLE_CYC(T_B)) dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b.master)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Miner model A: top-in byte shift on every rd_clk edge; result word latched
  // while wr_start is high and shifted down a byte on every wr_clk edge.
  logic [671:0] inbuf_a = '0;
  logic [95:0]  outbuf_a = '0;
  logic         rd_prev_a = 1'b0;
  logic         wr_prev_a = 1'b0;
  logic [31:0]  m_golden = '0, m_nonce = '0, m_hash2 = '0;
  always @(posedge clk) begin
    rd_prev_a <= bus_a.rd_clk;
    wr_prev_a <= bus_a.wr_clk;
    if (bus_a.rd_clk === ~rd_prev_a) inbuf_a <= {bus_a.read, inbuf_a[671:8]};
    if (bus_a.wr_start === 1'b1) outbuf_a <= {m_hash2, m_nonce, m_golden};
    else if (bus_a.wr_clk === ~wr_prev_a) outbuf_a <= {8'h00, outbuf_a[95:8]};
  end
  assign bus_a.write = outbuf_a[7:0];

  // Miner model B: load path only.
  logic [671:0] inbuf_b = '0;
  logic         rd_prev_b = 1'b0;
  always @(posedge clk) begin
    rd_prev_b <= bus_b.rd_clk;
    if (bus_b.rd_clk === ~rd_prev_b) inbuf_b <= {bus_b.read, inbuf_b[671:8]};
  end
  assign bus_b.write = 8'h00;

  // Scoreboard queues filled by the stimulus side.
  wide_t load_q_a[$];
  wide_t load_q_b[$];
  res_t  res_q_a[$];
  logic [31:0] last_rep = '0;

  task automatic checkOutput(input string name, input wide_t act, input wide_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic noteFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=missing required=present", name);
  endtask

  // Monitor: tracks accepts, then pops and compares when a load finishes,
  // a result is presented, or instance B toggles rd_clk.
  int   ncyc = 0;
  int   kind_a = 0, acc_a = 0, busy_cnt_a = 0;
  int   kind_b = 0, acc_b = 0, tog_b = 0;
  logic rdmon_b = 1'b0;
  always @(negedge clk) begin
    wide_t exp_ld;
    res_t  exp_r;
    ncyc = ncyc + 1;
    if (reset_a) begin
      kind_a = 0;
    end else begin
      if (kind_a != 0 && bus_a.busy === 1'b1) busy_cnt_a++;
      if (kind_a == 1 && bus_a.work_ready === 1'b1) begin
        if (load_q_a.size() == 0) noteFail("load_a_expectation");
        else begin
          exp_ld = load_q_a.pop_front();
          checkOutput("load_a_inbuf", inbuf_a, exp_ld);
        end
        checkOutput("load_a_latency", wide_t'(ncyc - acc_a), wide_t'(1 + 168 * S_A));
        checkOutput("load_a_busy_cycles", wide_t'(busy_cnt_a), wide_t'(168 * S_A));
        kind_a = 0;
      end
      if (bus_a.result_valid === 1'b1) begin
        if (kind_a != 2) checkOutput("spurious_result_valid", wide_t'(bus_a.result_valid), '0);
        else begin
          if (res_q_a.size() == 0) noteFail("result_expectation");
          else begin
            exp_r = res_q_a.pop_front();
            checkOutput("golden_nonce", wide_t'(bus_a.golden_nonce), wide_t'(exp_r.g));
            checkOutput("nonce", wide_t'(bus_a.nonce), wide_t'(exp_r.n));
            checkOutput("hash2", wide_t'(bus_a.hash2), wide_t'(exp_r.h));
            checkOutput("golden_new", wide_t'(bus_a.golden_new), wide_t'(exp_r.gn));
          end
          checkOutput("poll_latency", wide_t'(ncyc - acc_a), wide_t'(2 + S_A + T_A + 22 * S_A));
          kind_a = 0;
        end
      end
      if (kind_a == 0 && bus_a.work_ready === 1'b1) begin
        if (bus_a.work_valid) begin
          kind_a = 1; acc_a = ncyc; busy_cnt_a = 0;
        end else if (bus_a.poll_req) begin
          kind_a = 2; acc_a = ncyc; busy_cnt_a = 0;
        end
      end
    end
    if (reset_b) begin
      kind_b = 0;
    end else begin
      if (kind_b == 1 && bus_b.rd_clk !== rdmon_b) begin
        checkOutput("b_toggle_cycle", wide_t'(ncyc - acc_b), wide_t'(1 + (2 * tog_b + 1) * S_B));
        tog_b++;
      end
      if (kind_b == 1 && bus_b.work_ready === 1'b1) begin
        checkOutput("b_toggle_count", wide_t'(tog_b), wide_t'(84));
        checkOutput("b_latency", wide_t'(ncyc - acc_b), wide_t'(1 + 168 * S_B));
        if (load_q_b.size() == 0) noteFail("load_b_expectation");
        else begin
          exp_ld = load_q_b.pop_front();
          checkOutput("load_b_inbuf", inbuf_b, exp_ld);
        end
        kind_b = 0;
      end
      if (kind_b == 0 && bus_b.work_ready === 1'b1 && bus_b.work_valid) begin
        kind_b = 1; acc_b = ncyc; tog_b = 0;
      end
    end
    rdmon_b = bus_b.rd_clk;
  end

  // Drive the request inputs of one instance just after a rising edge.
  task automatic applyStimulus(input bit sel_b, input logic wv, input wide_t wd, input logic pr);
    @(posedge clk);
    #1;
    if (sel_b) begin
      bus_b.work_valid = wv; bus_b.work_data = wd; bus_b.poll_req = pr;
    end else begin
      bus_a.work_valid = wv; bus_a.work_data = wd; bus_a.poll_req = pr;
    end
  endtask

  task automatic waitDrain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (kind_a == 0 && kind_b == 0 && load_q_a.size() == 0 &&
              res_q_a.size() == 0 && load_q_b.size() == 0 &&
              bus_a.work_ready === 1'b1 && bus_b.work_ready === 1'b1);
    end
    if (!done) noteFail("drain_timeout");
  endtask

  task automatic pushResult(input logic [31:0] g, input logic [31:0] n, input logic [31:0] h);
    res_t r;
    m_golden = g; m_nonce = n; m_hash2 = h;
    r.g = g; r.n = n; r.h = h;
`ifdef ZTEXHOST_GOLDEN_DEDUP_EN
    r.gn = (g != last_rep);
`else
    r.gn = 1'b1;
`endif
    last_rep = g;
    res_q_a.push_back(r);
  endtask

  task automatic doPoll(input logic [31:0] g, input logic [31:0] n, input logic [31:0] h);
    pushResult(g, n, h);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    waitDrain(500);
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, "_read"}, wide_t'(bus_a.read), '0);
    checkOutput({tag, "_rd_clk"}, wide_t'(bus_a.rd_clk), '0);
    checkOutput({tag, "_wr_start"}, wide_t'(bus_a.wr_start), '0);
    checkOutput({tag, "_wr_clk"}, wide_t'(bus_a.wr_clk), '0);
    checkOutput({tag, "_work_ready"}, wide_t'(bus_a.work_ready), wide_t'(1));
    checkOutput({tag, "_busy"}, wide_t'(bus_a.busy), '0);
    checkOutput({tag, "_result_valid"}, wide_t'(bus_a.result_valid), '0);
    checkOutput({tag, "_golden_new"}, wide_t'(bus_a.golden_new), '0);
    checkOutput({tag, "_golden_nonce"}, wide_t'(bus_a.golden_nonce), '0);
    checkOutput({tag, "_nonce"}, wide_t'(bus_a.nonce), '0);
    checkOutput({tag, "_hash2"}, wide_t'(bus_a.hash2), '0);
  endtask

  // Directed sequence.
  initial begin
    wide_t pat_idx, pat_mix, pat_b;
    int    idle_cnt;
    bit    seen;
    for (int k = 0; k < 84; k++) begin
      pat_idx[8*k +: 8] = 8'(k);
      pat_mix[8*k +: 8] = 8'(3 * k + 7);
      pat_b[8*k +: 8]   = 8'(k) ^ 8'h5A;
    end
    reset_a = 1'b1; reset_b = 1'b1;
    bus_a.work_valid = 1'b0; bus_a.work_data = '0; bus_a.poll_req = 1'b0;
    bus_b.work_valid = 1'b0; bus_b.work_data = '0; bus_b.poll_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetA("reset");
    reset_a = 1'b0; reset_b = 1'b0;

    $display("[TB] load, byte k = k");
    load_q_a.push_back(pat_idx);
    applyStimulus(1'b0, 1'b1, pat_idx, 1'b0);
    applyStimulus(1'b0, 1'b0, pat_idx, 1'b0);
    waitDrain(2000);

    $display("[TB] polls");
    doPoll(32'h11223344, 32'hA5A5_0001, 32'h0000_0000);
    doPoll(32'h11223344, 32'hA5A5_0001, 32'h0000_0000);
    doPoll(32'h55667788, 32'hDEAD_BEEF, 32'h0BAD_F00D);

    $display("[TB] load and poll raised together");
    load_q_a.push_back(pat_mix);
    pushResult(32'hCAFE_BABE, 32'h0102_0304, 32'hF0E1_D2C3);
    applyStimulus(1'b0, 1'b1, pat_mix, 1'b1);
    applyStimulus(1'b0, 1'b0, pat_mix, 1'b1);
    idle_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (bus_a.wr_start === 1'b1) seen = 1'b1;
      else if (bus_a.work_ready === 1'b1) idle_cnt++;
    end
    checkOutput("poll_after_load", wide_t'(seen), wide_t'(1));
    checkOutput("idle_gap_cycles", wide_t'(idle_cnt), wide_t'(1));
    applyStimulus(1'b0, 1'b0, pat_mix, 1'b0);
    waitDrain(500);

    $display("[TB] reset during byte 40");
    applyStimulus(1'b0, 1'b1, pat_mix, 1'b0);
    applyStimulus(1'b0, 1'b0, pat_mix, 1'b0);
    repeat (326) @(posedge clk);
    #1;
    checkOutput("byte40_read", wide_t'(bus_a.read), wide_t'(pat_mix[327:320]));
    checkOutput("byte40_rd_clk", wide_t'(bus_a.rd_clk), wide_t'(1));
    reset_a = 1'b1;
    @(posedge clk);
    #1;
    checkResetA("abort");
    reset_a = 1'b0;
    last_rep = '0;
    load_q_a.push_back(pat_idx);
    applyStimulus(1'b0, 1'b1, pat_idx, 1'b0);
    applyStimulus(1'b0, 1'b0, pat_idx, 1'b0);
    waitDrain(2000);
    doPoll(32'hCAFE_BABE, 32'h7777_0000, 32'h0000_0001);

    $display("[TB] long strobe load");
    load_q_b.push_back(pat_b);
    applyStimulus(1'b1, 1'b1, pat_b, 1'b0);
    applyStimulus(1'b1, 1'b0, pat_b, 1'b0);
    waitDrain(45000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
